banked_mem_responder: RTL and testbench
=======================================

// Module: banked_mem_responder
// PURPOSE
//  Responder end of the four-bank memory interface driven by the cache controller FSM.
//  Implements a 4-way word-interleaved 16-bit memory: addr[2:1] selects bank, addr[15:3] is the row.
//  Per-bank busy flags let the initiator pipeline one request per cycle to successive banks.
//  Sits below the cache, as the backing store for both the instruction and data caches.
// PARAMETERS
//  ROW_W      13  row index bits per bank (rows = 2**ROW_W; row = addr[ROW_W+2:3])
//  BANK_OCC    4  cycles a bank is occupied per access, including the accept cycle
//  RD_LAT      2  cycles from read accept to data_out valid
// PORTS
//  clk       in   1   system clock, all state on posedge
//  rst       in   1   synchronous, active-high reset
//  addr      in  16   byte address; addr[0] must be 0
//  data_in   in  16   write data
//  wr        in   1   write request
//  rd        in   1   read request
//  data_out  out 16   read data, valid only in the cycle RD_LAT after the read accept; 16'd0 otherwise
//  busy      out  4   busy[b]=1: bank b cannot accept a request this cycle
//  err       out  1   combinational error flag for the current-cycle request
// BEHAVIOUR
//  - Reset: busy=0, data_out=0, err=0, all occupancy counters and read pipeline stages cleared.
//    Array contents are NOT cleared. Reset mid-operation drops in-flight reads: no data is delivered.
//  - Request: req = rd|wr, bank b = addr[2:1].
//  - Accept: req & ~busy[b] & ~(rd&wr) & ~addr[0] in cycle T.
//  - Write accept: mem[b][row] <= data_in at the T edge.
//  - Read accept: mem[b][row] is sampled at T and shifted through an RD_LAT-stage valid/data pipe.
//    data_out equals that word during cycle T+RD_LAT.
//  - Occupancy: counter[b] loads BANK_OCC-1 at accept; busy[b] = (counter[b]!=0).
//    busy[b] is therefore high T+1..T+BANK_OCC-1, and the bank is free again at T+BANK_OCC.
//  - Acceptance never depends on busy of other banks.
//    Back-to-back requests to banks 0,1,2,3 in cycles T..T+3 are all accepted.
//  - At most one request per cycle, so read pipeline outputs never collide.
//  - Read-after-write ordering:
//    - A read accepted after a write to the same row sees the new data.
//    - In the same cycle, a read and a write to the same bank are impossible (one request only).
//  - err=1 when req & (rd&wr | addr[0]). The request is dropped: no array update, no busy.
//  - Conflict: req to a bank with busy[b]=1 is not accepted (see CONFIGURATION for err).
//    The initiator holds its request until busy[b]=0. Holding the request does not extend busy.
//  - Idle (rd=wr=0): err=0, no state change except counter decrement and pipe shift.
// CONFIGURATION
//  BANKMEM_CONFLICT_ERR_EN defined:
//    - a request to a busy bank also raises err that cycle.
//    - This is a debug aid for initiators that must never issue into a busy bank.
//  Not defined:
//    - a conflicting request is silently stalled: not accepted, err=0.
//    - This is the normal hold-until-not-busy handshake used by the cache FSM.
// STRUCTURE
//  Shared package/include bank_mem_defs:
//    - NUM_BANKS=4
//    - BANK_SEL_LSB=1
//    - ROW_LSB=3
//    - defaults for BANK_OCC and RD_LAT
//    - a bank_sel() helper constant function
//  Sub-module bank_occ_timer:
//    - one per bank, generated 4x
//    - inputs: accept pulse
//    - holds the down-counter; outputs busy
//  Top level holds:
//    - the storage arrays
//    - accept/err decode
//    - the shared RD_LAT read pipeline
// TESTING
//  1. rst high 2 cycles with rd=1 -> busy=0, data_out=0, err=0 throughout, and for one cycle after release.
//  2. wr addr 16'h0010 data 16'hBEEF at T, then rd 16'h0010 at T+4.
//     -> busy[0]=1 at T+1..T+3, data_out=16'hBEEF at T+6 only.
//  3. rd of 16'h0020,0022,0024,0026 in T..T+3, preloaded with 16'h1111..4444.
//     -> data_out 16'h1111..4444 at T+2..T+5; busy[b] rises T+1+b.
//  4. rd 16'h0000 at T and again at T+1, T+2, T+3 (held).
//     -> the hold is not accepted until T+4; data at T+2 and T+6.
//     -> err=0 without BANKMEM_CONFLICT_ERR_EN; err=1 at T+1..T+3 with it.
//  5. rd&wr together, and rd at addr 16'h0011 -> err=1 same cycle, busy stays 0, memory unchanged on readback.
//  6. rd 16'h0040 at T, rst at T+1 -> data_out=0 at T+2, all busy=0 at T+2.

Source files
------------

// File: rtl/banked_mem_responder_pkg.sv
// Shared definitions for the four-bank word-interleaved memory responder:
// bank/row address geometry, default timing parameters and the bank-select helper.
package bank_mem_defs;

  localparam int unsigned NUM_BANKS    = 4;
  localparam int unsigned BANK_W       = 2;
  localparam int unsigned BANK_SEL_LSB = 1;
  localparam int unsigned ROW_LSB      = 3;
  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned DATA_W       = 16;

  localparam int unsigned DEF_ROW_W    = 13;
  localparam int unsigned DEF_BANK_OCC = 4;
  localparam int unsigned DEF_RD_LAT   = 2;

  // Bank index of a byte address: consecutive 16-bit words rotate through the banks.
  function automatic logic [BANK_W-1:0] bank_sel(input logic [ADDR_W-1:0] a);
    return a[BANK_SEL_LSB +: BANK_W];
  endfunction

endpackage

// File: rtl/banked_mem_responder_bank_occ_timer.sv
// Per-bank occupancy timer: an accept pulse loads BANK_OCC-1 into a down-counter,
// and the bank reports busy while the counter is non-zero.
module bank_occ_timer #(
  parameter int unsigned BANK_OCC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic accept_i,
  output logic busy_o
);

  localparam int unsigned CNT_W = $clog2(BANK_OCC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             busy_q;

  // Next counter value: reload on accept, otherwise count down to zero and hold there.
  always_comb begin
    cnt_d = cnt_q;
    if (accept_i) begin
      cnt_d = CNT_W'(BANK_OCC - 1);
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Counter and registered busy flag; busy mirrors the counter's next value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= {CNT_W{1'b0}};
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != {CNT_W{1'b0}});
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank word-interleaved 16-bit memory responder.
// addr[2:1] selects the bank, addr[ROW_W+2:3] the row. Each bank stays busy for
// BANK_OCC cycles per access; reads return data RD_LAT cycles after accept.
// Optional build macro: BANKMEM_CONFLICT_ERR_EN -- when defined, a request that
// targets a busy bank also raises err (debug aid); otherwise such a request is
// silently stalled until the bank frees up.
module banked_mem_responder
  import bank_mem_defs::*;
#(
  parameter int unsigned ROW_W    = DEF_ROW_W,
  parameter int unsigned BANK_OCC = DEF_BANK_OCC,
  parameter int unsigned RD_LAT   = DEF_RD_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 wr,
  input  logic                 rd,
  output logic [DATA_W-1:0]    data_out,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  localparam int unsigned ROWS = 32'd1 << ROW_W;

  // Storage: one array per bank, never reset.
  logic [DATA_W-1:0] mem_q [NUM_BANKS][ROWS];

  // Request decode
  logic [BANK_W-1:0]    bank;
  logic [ROW_W-1:0]     row;
  logic                 req;
  logic                 malformed;
  logic                 bank_busy;
  logic                 accept;
  logic                 wr_acc;
  logic                 rd_acc;
  logic [NUM_BANKS-1:0] accept_vec;
  logic [NUM_BANKS-1:0] busy_vec;
  logic [DATA_W-1:0]    rd_word;

  // Read pipeline
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] vld_d;
  logic [DATA_W-1:0] pdata_q [RD_LAT];
  logic [DATA_W-1:0] pdata_d [RD_LAT];

  assign bank      = bank_sel(addr);
  assign row       = addr[ROW_LSB +: ROW_W];
  assign req       = rd | wr;
  assign malformed = (rd & wr) | addr[0];
  assign bank_busy = busy_vec[bank];
  assign rd_word   = mem_q[bank][row];

  // Accept/err decode. Reset masks both so nothing is accepted or flagged while held.
  always_comb begin
    accept = 1'b0;
    err    = 1'b0;
    if (rst) begin
      accept = 1'b0;
      err    = 1'b0;
    end else begin
      accept = req & ~malformed & ~bank_busy;
`ifdef BANKMEM_CONFLICT_ERR_EN
      err    = req & (malformed | bank_busy);
`else
      err    = req & malformed;
`endif
    end
    wr_acc = accept & wr;
    rd_acc = accept & rd;
  end

  // One-hot accept pulse toward the selected bank's occupancy timer.
  always_comb begin
    accept_vec = {NUM_BANKS{1'b0}};
    for (int b = 0; b < NUM_BANKS; b++) begin
      accept_vec[b] = accept & (bank == BANK_W'(b));
    end
  end

  for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
    bank_occ_timer #(
      .BANK_OCC (BANK_OCC)
    ) u_occ (
      .clk      (clk),
      .rst      (rst),
      .accept_i (accept_vec[gb]),
      .busy_o   (busy_vec[gb])
    );
  end

  assign busy = busy_vec;

  // Array write on an accepted write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[bank][row] <= data_in;
    end
  end

  // Read pipe next state: stage 0 captures the addressed word on a read accept,
  // later stages shift; data is forced to zero in any stage without a valid read.
  always_comb begin
    vld_d = {RD_LAT{1'b0}};
    for (int i = 0; i < RD_LAT; i++) begin
      pdata_d[i] = {DATA_W{1'b0}};
    end
    vld_d[0]   = rd_acc;
    pdata_d[0] = rd_acc ? rd_word : {DATA_W{1'b0}};
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]   = vld_q[i-1];
      pdata_d[i] = vld_q[i-1] ? pdata_q[i-1] : {DATA_W{1'b0}};
    end
  end

  // Read pipe registers; reset flushes every in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        pdata_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < RD_LAT; i++) begin
        pdata_q[i] <= pdata_d[i];
      end
    end
  end

  assign data_out = vld_q[RD_LAT-1] ? pdata_q[RD_LAT-1] : {DATA_W{1'b0}};

endmodule

// File: tb/tb_banked_mem_responder.sv
// Directed self-checking bench for banked_mem_responder (default parameters).
// Honours BANKMEM_CONFLICT_ERR_EN for the expected err on a busy-bank request.
module tb_banked_mem_responder;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic [3:0]  busy;
  logic        err;

  int n_assert;
  int n_fail;
  logic conf_err;

  banked_mem_responder dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .rd       (rd),
    .data_out (data_out),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs just after a rising edge, return mid-cycle for checking.
  task automatic drive(input logic r, input logic rd_v, input logic wr_v,
                       input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    rst = r; rd = rd_v; wr = wr_v; addr = a; data_in = d;
    #4;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
`ifdef BANKMEM_CONFLICT_ERR_EN
    conf_err = 1'b1;
`else
    conf_err = 1'b0;
`endif
    rst = 1'b1; rd = 1'b1; wr = 1'b0; addr = 16'h0000; data_in = 16'h0000;

    // 1: reset held two cycles with rd asserted, then one cycle after release
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
      chk("rst_busy", busy, 4'b0000);
      chk("rst_dout", data_out, 16'h0000);
      chk("rst_err", err, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("rel_busy", busy, 4'b0000);
    chk("rel_dout", data_out, 16'h0000);
    chk("rel_err", err, 1'b0);
    idle(5);

    // 2: write then read back bank 0 row 2
    drive(1'b0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
    chk("t2_wr_err", err, 1'b0);
    chk("t2_wr_busy", busy, 4'b0000);
    for (int i = 1; i <= 3; i++) begin
      idle(1);
      chk("t2_busy_occ", busy, 4'b0001);
      chk("t2_dout_idle", data_out, 16'h0000);
    end
    drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("t2_rd_busy", busy, 4'b0000);
    chk("t2_rd_err", err, 1'b0);
    idle(1);
    chk("t2_dout_t5", data_out, 16'h0000);
    idle(1);
    chk("t2_dout_t6", data_out, 16'hBEEF);
    idle(1);
    chk("t2_dout_t7", data_out, 16'h0000);
    idle(4);

    // 3: preload four banks, then pipelined reads across them
    drive(1'b0, 1'b0, 1'b1, 16'h0020, 16'h1111);
    drive(1'b0, 1'b0, 1'b1, 16'h0022, 16'h2222);
    drive(1'b0, 1'b0, 1'b1, 16'h0024, 16'h3333);
    drive(1'b0, 1'b0, 1'b1, 16'h0026, 16'h4444);
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'hA5A5);
    drive(1'b0, 1'b0, 1'b1, 16'h0042, 16'h7777);
    idle(5);
    drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    chk("t3_busy_t0", busy, 4'b0000);
    chk("t3_dout_t0", data_out, 16'h0000);
    drive(1'b0, 1'b1, 1'b0, 16'h0022, 16'h0000);
    chk("t3_busy_t1", busy, 4'b0001);
    chk("t3_err_t1", err, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 16'h0024, 16'h0000);
    chk("t3_busy_t2", busy, 4'b0011);
    chk("t3_dout_t2", data_out, 16'h1111);
    drive(1'b0, 1'b1, 1'b0, 16'h0026, 16'h0000);
    chk("t3_busy_t3", busy, 4'b0111);
    chk("t3_dout_t3", data_out, 16'h2222);
    idle(1);
    chk("t3_busy_t4", busy, 4'b1110);
    chk("t3_dout_t4", data_out, 16'h3333);
    idle(1);
    chk("t3_busy_t5", busy, 4'b1100);
    chk("t3_dout_t5", data_out, 16'h4444);
    idle(1);
    chk("t3_busy_t6", busy, 4'b1000);
    chk("t3_dout_t6", data_out, 16'h0000);
    idle(4);

    // 4: read held against its own busy bank
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("t4_err_t0", err, 1'b0);
    chk("t4_busy_t0", busy, 4'b0000);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
      chk("t4_busy_hold", busy, 4'b0001);
      chk("t4_err_hold", err, conf_err);
      chk("t4_dout_hold", data_out, (i == 2) ? 16'hA5A5 : 16'h0000);
    end
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("t4_busy_t4", busy, 4'b0000);
    chk("t4_err_t4", err, 1'b0);
    idle(1);
    chk("t4_busy_t5", busy, 4'b0001);
    chk("t4_dout_t5", data_out, 16'h0000);
    idle(1);
    chk("t4_dout_t6", data_out, 16'hA5A5);
    idle(4);

    // 5: malformed requests are flagged and dropped
    drive(1'b0, 1'b1, 1'b1, 16'h0020, 16'hDEAD);
    chk("t5_rdwr_err", err, 1'b1);
    idle(1);
    chk("t5_rdwr_busy", busy, 4'b0000);
    chk("t5_idle_err", err, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000);
    chk("t5_odd_rd_err", err, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 16'h0023, 16'hDEAD);
    chk("t5_odd_wr_err", err, 1'b1);
    chk("t5_odd_rd_busy", busy, 4'b0000);
    idle(1);
    chk("t5_odd_wr_busy", busy, 4'b0000);
    chk("t5_odd_rd_dout", data_out, 16'h0000);
    drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    drive(1'b0, 1'b1, 1'b0, 16'h0022, 16'h0000);
    idle(1);
    chk("t5_rb_bank0", data_out, 16'h1111);
    idle(1);
    chk("t5_rb_bank1", data_out, 16'h2222);
    idle(4);

    // 6: reset right after a read accept drops the read
    drive(1'b0, 1'b1, 1'b0, 16'h0042, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("t6_dout_t2", data_out, 16'h0000);
    chk("t6_busy_t2", busy, 4'b0000);
    idle(1);
    chk("t6_dout_t3", data_out, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
